// File: rtl/zbuf_pkg.sv
// Shared types and constants for the Z-buffer pipeline: screen geometry, depth
// and colour formats, and the fragment-writer state encoding.
package zbuf_pkg;

    localparam int SCREEN_W = 16;
    localparam int SCREEN_H = 16;
    localparam int Z_W      = 8;
    localparam int COORD_W  = 4;
    localparam int CID_W    = 4;
    localparam int ADDR_W   = 8;

    typedef logic [23:0]       color_t;
    typedef logic [ADDR_W-1:0] pix_addr_t;
    typedef logic [Z_W-1:0]    depth_t;

    localparam depth_t    Z_FAR    = '1;
    localparam color_t    BG_COLOR = 24'h000000;
    localparam pix_addr_t CLR_LAST = pix_addr_t'(SCREEN_W * SCREEN_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_CMP,
        ST_CLEAR
    } state_e;

endpackage

// File: rtl/zbuf_addr_calc.sv
// Linear pixel address from screen coordinates; shared with the rasteriser.
module zbuf_addr_calc
    import zbuf_pkg::*;
(
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output pix_addr_t          addr_o
);

    assign addr_o = pix_addr_t'(int'(y_i) * SCREEN_W + int'(x_i));

endmodule

// File: rtl/zbuf_fragment_writer.sv
// Depth-test and write-back stage: read-compare-write on the depth RAM for each
// fragment, frame-buffer write on a win, and a full-screen clear on request.
module zbuf_fragment_writer
    import zbuf_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               frag_valid_i,
    output logic               frag_ready_o,
    input  logic [COORD_W-1:0] frag_x_i,
    input  logic [COORD_W-1:0] frag_y_i,
    input  depth_t             frag_z_i,
    input  logic [CID_W-1:0]   frag_cid_i,
    input  logic               clear_start_i,
    output logic               busy_o,
    output logic [CID_W-1:0]   rom_addr_o,
    input  color_t             rom_data_i,
    output pix_addr_t          zb_addr_o,
    input  depth_t             zb_rd_data_i,
    output logic               zb_we_o,
    output depth_t             zb_wr_data_o,
    output pix_addr_t          fb_addr_o,
    output logic               fb_we_o,
    output color_t             fb_wr_data_o,
    output logic               pix_written_o,
    output logic               pix_rejected_o
);

    state_e             state_q, state_d;
    pix_addr_t          clr_cnt_q, clr_cnt_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    depth_t             z_q, z_d;
    logic [CID_W-1:0]   cid_q, cid_d;
    pix_addr_t          pix_addr;

    zbuf_addr_calc u_addr_calc (
        .x_i    (x_q),
        .y_i    (y_q),
        .addr_o (pix_addr)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            cid_q     <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            cid_q     <= cid_d;
        end
    end

    // The ROM is combinational, so the latched index alone selects the colour.
    assign rom_addr_o = cid_q;
    assign busy_o     = (state_q != ST_IDLE);

    always_comb begin
        state_d        = state_q;
        clr_cnt_d      = clr_cnt_q;
        x_d            = x_q;
        y_d            = y_q;
        z_d            = z_q;
        cid_d          = cid_q;
        frag_ready_o   = 1'b0;
        zb_addr_o      = '0;
        fb_addr_o      = '0;
        zb_we_o        = 1'b0;
        fb_we_o        = 1'b0;
        zb_wr_data_o   = '0;
        fb_wr_data_o   = '0;
        pix_written_o  = 1'b0;
        pix_rejected_o = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A clear request blocks the fragment handshake in the same cycle.
                frag_ready_o = ~clear_start_i;
                if (clear_start_i) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (frag_valid_i) begin
                    x_d     = frag_x_i;
                    y_d     = frag_y_i;
                    z_d     = frag_z_i;
                    cid_d   = frag_cid_i;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                zb_addr_o = pix_addr;
                fb_addr_o = pix_addr;
                state_d   = ST_CMP;
            end
            ST_CMP: begin
                zb_addr_o = pix_addr;
                fb_addr_o = pix_addr;
                if (z_q < zb_rd_data_i) begin
                    zb_we_o       = 1'b1;
                    fb_we_o       = 1'b1;
                    zb_wr_data_o  = z_q;
                    fb_wr_data_o  = rom_data_i;
                    pix_written_o = 1'b1;
                end else begin
                    pix_rejected_o = 1'b1;
                end
                state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                zb_addr_o    = clr_cnt_q;
                fb_addr_o    = clr_cnt_q;
                zb_we_o      = 1'b1;
                fb_we_o      = 1'b1;
                zb_wr_data_o = Z_FAR;
                fb_wr_data_o = BG_COLOR;
                clr_cnt_d    = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_zbuf_fragment_writer.sv
// Scoreboarded bench: a per-pixel depth/colour model predicts every write or
// reject event; a monitor compares each event the DUT presents.
module tb_zbuf_fragment_writer;
    import zbuf_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         frag_valid = 1'b0, frag_ready;
    logic [3:0]   frag_x = '0, frag_y = '0, frag_cid = '0;
    logic [7:0]   frag_z = '0;
    logic         clear_start = 1'b0, busy;
    logic [3:0]   rom_addr;
    logic [23:0]  rom_data;
    logic [7:0]   zb_addr, zb_rd_data, zb_wr_data, fb_addr;
    logic         zb_we, fb_we, pix_written, pix_rejected;
    logic [23:0]  fb_wr_data;

    zbuf_fragment_writer dut (
        .clk_i(clk), .rst_i(rst),
        .frag_valid_i(frag_valid), .frag_ready_o(frag_ready),
        .frag_x_i(frag_x), .frag_y_i(frag_y), .frag_z_i(frag_z), .frag_cid_i(frag_cid),
        .clear_start_i(clear_start), .busy_o(busy),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .zb_addr_o(zb_addr), .zb_rd_data_i(zb_rd_data),
        .zb_we_o(zb_we), .zb_wr_data_o(zb_wr_data),
        .fb_addr_o(fb_addr), .fb_we_o(fb_we), .fb_wr_data_o(fb_wr_data),
        .pix_written_o(pix_written), .pix_rejected_o(pix_rejected)
    );

    always #5 clk = ~clk;

    // Colour ROM and the two RAMs the DUT drives.
    logic [23:0] rom [16];
    logic [7:0]  zmem [256];
    logic [23:0] fmem [256];
    assign rom_data = rom[rom_addr];
    always @(posedge clk) begin
        if (zb_we) zmem[zb_addr] <= zb_wr_data;
        if (fb_we) fmem[fb_addr] <= fb_wr_data;
        zb_rd_data <= zmem[zb_addr];
    end

    // Reference picture and expected event stream.
    typedef struct {
        int          kind;   // 0 clear write, 1 fragment win, 2 fragment reject
        logic [7:0]  addr;
        logic [7:0]  z;
        logic [23:0] c;
        logic [3:0]  cid;
    } ev_t;
    ev_t         expq [$];
    logic [7:0]  ref_z [256];
    logic [23:0] ref_c [256];

    int n_chk = 0, n_fail = 0;
    int m_rem = 0;          // busy cycles remaining, counted from the current cycle
    bit m_clearing = 0;
    int m_cidx = 0;
    int ncyc = 0;
    bit accepted = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (zb_we || fb_we || pix_written || pix_rejected) begin
            if (expq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_event: got addr %0h we %0b%0b, expected no event", zb_addr, zb_we, fb_we);
            end else begin
                ev_t e;
                e = expq.pop_front();
                chk("ev_addr", {zb_addr, fb_addr}, {e.addr, e.addr});
                case (e.kind)
                    0: begin
                        chk("clr_ctl", {zb_we, fb_we, pix_written, pix_rejected}, 4'b1100);
                        chk("clr_data", {zb_wr_data, fb_wr_data}, {Z_FAR, BG_COLOR});
                    end
                    1: begin
                        chk("win_ctl", {zb_we, fb_we, pix_written, pix_rejected}, 4'b1110);
                        chk("win_data", {zb_wr_data, fb_wr_data}, {e.z, e.c});
                        chk("win_rom_addr", rom_addr, e.cid);
                    end
                    default: begin
                        chk("rej_ctl", {zb_we, fb_we, pix_written, pix_rejected}, 4'b0001);
                        chk("rej_rom_addr", rom_addr, e.cid);
                    end
                endcase
            end
        end
    end

    task automatic push_clear(input int k);
        ev_t e;
        e = '{kind: 0, addr: 8'(k), z: 8'hFF, c: 24'h0, cid: 4'h0};
        expq.push_back(e);
        ref_z[k] = 8'hFF;
        ref_c[k] = 24'h000000;
    endtask

    task automatic push_frag(input logic [3:0] x, input logic [3:0] y, input logic [7:0] z, input logic [3:0] cid);
        ev_t e;
        int a;
        a = int'(y) * 16 + int'(x);
        e = '{kind: 2, addr: 8'(a), z: z, c: rom[cid], cid: cid};
        if (z < ref_z[a]) begin
            e.kind = 1;
            ref_z[a] = z;
            ref_c[a] = rom[cid];
        end
        expq.push_back(e);
    endtask

    // One clock cycle: drive inputs after the falling edge, check the
    // handshake view, then advance the model to what the next cycle holds.
    task automatic cycle(input logic v, input logic [3:0] x, input logic [3:0] y, input logic [7:0] z,
                         input logic [3:0] cid, input logic clr, input logic r);
        @(negedge clk);
        rst = r; frag_valid = v; frag_x = x; frag_y = y; frag_z = z; frag_cid = cid; clear_start = clr;
        #1;
        chk("busy", busy, m_rem != 0);
        chk("frag_ready", frag_ready, (m_rem == 0) && !clr);
        accepted = 0;
        if (r) begin
            m_rem = 0;
            m_clearing = 0;
        end else if (m_rem == 0) begin
            if (clr) begin
                m_rem = 256; m_clearing = 1; m_cidx = 0;
                push_clear(0);
            end else if (v) begin
                push_frag(x, y, z, cid);
                m_rem = 2;
                accepted = 1;
            end
        end else begin
            m_rem--;
            if (m_clearing) begin
                if (m_rem == 0) m_clearing = 0;
                else begin
                    m_cidx++;
                    push_clear(m_cidx);
                end
            end
        end
        ncyc++;
    endtask

    task automatic idle();
        cycle(1'b0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic send_frag(input logic [3:0] x, input logic [3:0] y, input logic [7:0] z,
                             input logic [3:0] cid, output int acc_at);
        int n = 0;
        accepted = 0;
        while (!accepted && n < 400) begin
            cycle(1'b1, x, y, z, cid, 1'b0, 1'b0);
            n++;
        end
        if (!accepted) chk("accept_timeout", 0, 1);
        acc_at = ncyc;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_rem != 0 && n < 400) begin
            idle();
            n++;
        end
        if (m_rem != 0) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, prev, i0, nb;
        for (int i = 0; i < 16; i++) rom[i] = 24'($urandom);
        for (int i = 0; i < 256; i++) begin ref_z[i] = '0; ref_c[i] = '0; end

        // Reset and its output state.
        cycle(1'b0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b1);
        cycle(1'b0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b1);
        idle();
        chk("rst_ctl", {zb_we, fb_we, pix_written, pix_rejected, busy}, 5'b0);
        chk("rst_addr", {zb_addr, fb_addr, rom_addr}, 20'h0);
        chk("rst_data", {zb_wr_data, fb_wr_data}, 32'h0);

        // Full clear: busy for exactly 256 cycles.
        cycle(1'b0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b1, 1'b0);
        nb = 0;
        for (int i = 0; i < 262; i++) begin
            idle();
            if (busy) nb++;
        end
        chk("clear_busy_cycles", nb, 256);

        // Fragment, occlusion, equal depth, closer, far fragment on a cleared pixel.
        send_frag(4'd3, 4'd2, 8'h40, 4'd4, acc); wait_idle(); idle();
        send_frag(4'd3, 4'd2, 8'h50, 4'd5, acc); wait_idle();
        send_frag(4'd3, 4'd2, 8'h40, 4'd6, acc); wait_idle();
        send_frag(4'd3, 4'd2, 8'h10, 4'd7, acc); wait_idle();
        send_frag(4'd7, 4'd9, 8'hFF, 4'd2, acc); wait_idle();
        send_frag(4'd15, 4'd15, 8'h00, 4'd15, acc); wait_idle();

        // Clear and fragment together: clear wins, fragment follows 257 cycles later.
        cycle(1'b1, 4'd5, 4'd5, 8'h20, 4'd7, 1'b1, 1'b0);
        i0 = ncyc;
        send_frag(4'd5, 4'd5, 8'h20, 4'd7, acc);
        chk("collision_accept_delay", acc - i0, 257);
        wait_idle();

        // Valid held continuously: one acceptance per three cycles.
        send_frag(4'($urandom), 4'($urandom), 8'($urandom), 4'($urandom), prev);
        for (int i = 0; i < 8; i++) begin
            send_frag(4'($urandom), 4'($urandom), 8'($urandom), 4'($urandom), acc);
            chk("bp_gap", acc - prev, 3);
            prev = acc;
        end
        wait_idle();

        // Reset while the clear counter sits at 100, then a fresh clear.
        cycle(1'b0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b1, 1'b0);
        repeat (100) idle();
        cycle(1'b0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b1);
        idle();
        chk("midclr_rst_ctl", {zb_we, fb_we, busy}, 3'b000);
        send_frag(4'd1, 4'd0, 8'h33, 4'd3, acc); wait_idle();
        cycle(1'b0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b1, 1'b0);
        wait_idle();

        // Random traffic with occasional clears.
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom),
                  8'($urandom_range(0, 255)), 4'($urandom),
                  $urandom_range(0, 149) == 0, 1'b0);
        end
        wait_idle();
        repeat (3) idle();

        chk("events_outstanding", expq.size(), 0);
        for (int a = 0; a < 256; a++) begin
            chk("zmem", zmem[a], ref_z[a]);
            chk("fmem", fmem[a], ref_c[a]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/zbuf_fragment_writer.md
# zbuf_fragment_writer

Depth-test and write-back stage of the Z-buffer pipeline. It accepts rasterised fragments (x, y, z, colour index), resolves the colour through the 16-entry 24-bit colour ROM, performs a read-compare-write on the depth memory and writes winning pixels to the frame buffer. It also runs a full-screen clear (far depth plus background colour) on request. It sits directly downstream of the colour ROM and upstream of the depth and frame-buffer RAMs.

## Interface
- SCREEN_W, 16, pixels per line (power of two)
- SCREEN_H, 16, lines per frame
- Z_W, 8, depth width; Z_FAR = all ones
- BG_COLOR, 24'h000000, colour written during clear
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- frag_valid  in  1  fragment present
- frag_ready  out  1  fragment accepted when valid&ready
- frag_x / frag_y  in  4 / 4  pixel coordinates
- frag_z  in  Z_W  depth; smaller is closer
- frag_cid  in  4  colour index
- clear_start  in  1  start-clear request (IDLE only)
- busy  out  1  high whenever state != IDLE
- rom_addr  out  4  colour ROM address (ROM read is combinational)
- rom_data  in  24  colour ROM data
- zb_addr  out  8  depth RAM address; read data one cycle later
- zb_rd_data  in  Z_W  depth RAM read data
- zb_we, zb_wr_data  out  1, Z_W  depth RAM write
- fb_addr, fb_we, fb_wr_data  out  8, 1, 24  frame-buffer write
- pix_written / pix_rejected  out  1 / 1  one-cycle result pulses

## Operation
- FSM states: IDLE, READ, CMP, CLEAR.
- IDLE: frag_ready = ~clear_start. If clear_start is high, go to CLEAR with clr_cnt = 0. Clear wins over a simultaneous fragment, and that fragment is not consumed. Otherwise, on valid&ready, latch x, y, z and cid, then go to READ.
- Address = y*SCREEN_W + x, 8 bits, formed from the latched coordinates. zb_addr and fb_addr both carry it in READ and CMP.
- rom_addr = latched cid in every state. In IDLE it holds the last value; it resets to 0.
- READ: depth RAM samples zb_addr; go to CMP.
- CMP: if z_lat < zb_rd_data, assert zb_we (data z_lat), fb_we (data rom_data) and pix_written. Otherwise assert pix_rejected with no writes. Go to IDLE.
- Equal depth is rejected (strict less-than). A fragment at Z_FAR never wins over a cleared pixel.
- CLEAR: each cycle, zb_addr = fb_addr = clr_cnt, zb_we = fb_we = 1, zb_wr_data = Z_FAR, fb_wr_data = BG_COLOR. clr_cnt increments. After address 255 is written, go to IDLE (256 cycles total, no wrap).
- clear_start outside IDLE is ignored. Fragments are never accepted outside IDLE.
- Reset (at any time, including mid-clear or mid-fragment):
  - state goes to IDLE and clr_cnt to 0;
  - all write enables, pulses and busy go to 0;
  - addresses and data outputs go to 0;
  - a partially cleared buffer stays partial.

## Timing
- Fragment: 3 cycles from acceptance edge to IDLE. Throughput is one fragment per 3 cycles.
- Accept at edge T: READ during T+1, CMP during T+2, writes commit at edge T+3, frag_ready is high again from T+3.
- pix_written / pix_rejected are high for exactly one cycle (the CMP cycle).
- Clear: clear_start sampled at edge T; write to address k happens during cycle T+1+k; busy falls after edge T+257.
- All outputs are decoded from registered state and latches. The only combinational input-to-output path is clear_start → frag_ready.

## Structure
- Shared package zbuf_pkg holds:
  - SCREEN_W, SCREEN_H, Z_W, Z_FAR, BG_COLOR;
  - the state enum typedef;
  - the 8-bit pixel-address typedef;
  - the 24-bit colour typedef (also used by the colour ROM).
- One sub-module, zbuf_addr_calc: combinational (x, y) → linear address, reused by the rasteriser.

## Test plan
- Clear then fragment: reset, pulse clear_start → 256 writes of FF/000000 to addresses 0..255, busy high 256 cycles. Then fragment x=3, y=2, z=0x40, cid=4 → at address 35 zb writes 0x40, fb writes ROM[4], pix_written pulses at T+2.
- Occlusion: after the above, fragment x=3, y=2, z=0x50 → pix_rejected, no writes. z=0x40 (equal) → rejected. z=0x10 → written.
- Collision: clear_start and frag_valid high together in IDLE → frag_ready=0, clear runs, fragment accepted 257 cycles later.
- Backpressure: frag_valid held through busy → exactly one acceptance per 3-cycle slot, no duplicate writes.
- Reset mid-clear: assert rst at clr_cnt=100 → next cycle IDLE, all enables 0, a new clear restarts from address 0.
- Corner pixel: x=15, y=15, z=0x00 → address 255 written, ROM address 15 selected.
